ram_arbiter: RTL
================

# ram_arbiter

Sequential arbiter for the single shared RAM port. It serves three requesters: CPU data, DMA, and CPU instruction fetch. Each winner is locked onto the RAM for the whole transaction, until the RAM reports `RAM_DONE`. A starvation counter guarantees forward progress for instruction fetch. It sits between the CPU/DMA request ports and `ram_if`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `STARVE_LIMIT`, 4, consecutive non-instruction grants while `iren` is pending before instruction fetch is forced to win

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `iren`  in  1  instruction read request
- `iaddr`  in  ADDR_W  instruction address
- `iwait`  out  1  low for exactly the completing cycle of an instruction grant
- `iload`  out  32  read data (pass-through of `ram_load`)
- `dren`  in  1  data read request
- `dwen`  in  4  data byte write enables
- `daddr`  in  ADDR_W  data address
- `dstore`  in  32  data write value
- `dwait`  out  1  data completion, same rule as `iwait`
- `dload`  out  32  read data
- `dma_ren`  in  1  DMA read request
- `dma_wen`  in  4  DMA byte write enables
- `dma_addr`  in  ADDR_W  DMA address
- `dma_store`  in  32  DMA write value
- `dma_wait`  out  1  DMA completion
- `dma_load`  out  32  read data
- `ram_ren`  out  1  RAM read strobe
- `ram_wen`  out  4  RAM byte write enables
- `ram_addr`  out  ADDR_W  RAM address
- `ram_store`  out  32  RAM write data
- `ram_load`  in  32  RAM read data
- `ram_state`  in  ram_state_t  RAM status; `RAM_DONE` marks completion

## Operation
- States:
  - `ARB_IDLE`: no owner.
  - `ARB_ACCESS`: owner latched in `owner` (`OWN_D`, `OWN_DMA`, `OWN_I`).
- A requester is active as follows:
  - D: `|dwen | dren`.
  - DMA: `|dma_wen | dma_ren`.
  - I: `iren`.
- Arbitration happens in `ARB_IDLE`.
  - Default priority: D > DMA > I.
  - If `starve_cnt == STARVE_LIMIT` and `iren` is high, I wins regardless of the others.
  - The winner is registered into `owner`, and the block moves to `ARB_ACCESS`.
  - With no active requester, the block stays in `ARB_IDLE`.
- In `ARB_ACCESS`, the RAM port is driven from the owner's live signals:
  - Writes take precedence over reads within one requester. If `|wen` is set, then `ram_wen = wen` and `ram_ren = 0`; otherwise `ram_ren = 1`.
  - `ram_store` follows the owner's store data.
  - The requester must hold address and data stable until its wait signal goes low.
- Completion: in `ARB_ACCESS` with `ram_state == RAM_DONE`:
  - The owner's wait goes low in that same cycle (combinational).
  - The next state is `ARB_IDLE`.
- Abort: in `ARB_ACCESS`, if the owner drops its request before `RAM_DONE`:
  - RAM strobes go to 0 in that same cycle.
  - The next state is `ARB_IDLE`.
  - No wait signal deasserts.
- Starvation counter `starve_cnt`:
  - Increments, saturating at `STARVE_LIMIT`, on each grant to D or DMA while `iren` is high.
  - Clears on a grant to I, and on any cycle with `iren` low.
- All three load outputs are continuously equal to `ram_load`. Only the wait signals qualify them.
- Reset values, and values whenever `rst` is high (forced combinationally):
  - `iwait`, `dwait`, `dma_wait` = 1.
  - `ram_ren` = 0, `ram_wen` = 0, `ram_addr` = 0, `ram_store` = 0.
  - State `ARB_IDLE`, `owner` = `OWN_NONE`, `starve_cnt` = 0.
- Reset mid-transaction: the transaction is dropped, with no wait deasserting. The RAM sees strobes low from the first reset cycle.

## Timing
- Request seen at edge N. RAM strobes are valid from cycle N+1. The minimum grant-to-done time is 1 cycle (`RAM_DONE` in the first `ARB_ACCESS` cycle).
- After every completion or abort, there is exactly one `ARB_IDLE` cycle. This gives the RAM a strobe-low cycle to leave `RAM_DONE`.
- Best-case throughput: one transaction per two cycles plus RAM latency.
- A request arriving during `ARB_ACCESS` waits. Its wait signal stays high.
- Simultaneous requests from all three are resolved only at the `ARB_IDLE` edge.
- Arbitration is non-preemptive: a higher-priority request never interrupts the current owner.

## Structure
- Add to `common_types_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t`
  - `typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_DMA, OWN_I} arb_owner_t`
- `ram_state_t` / `RAM_DONE` are reused from the same package.
- Sub-module `ram_arb_pick` is a purely combinational picker.
  - Inputs: the three active flags and the force-I flag.
  - Output: `arb_owner_t`.
- The counter, FSM and port mux stay in `ram_arbiter`.

## Test plan
- D read `daddr=0x100`, with RAM_DONE 3 cycles after the strobe:
  - `ram_ren=1` and `ram_addr=0x100` from cycle 1.
  - `dwait` is low only on the done cycle; `dload` equals `ram_load` there.
  - Then 1 idle cycle.
- `iren`, `dren`, `dma_ren` all raised at cycle 0, with RAM done after 2 cycles:
  - Grant order is D, DMA, I.
  - Each wait drops exactly once.
- D and DMA issue back-to-back requests continuously while `iren` is held, with `STARVE_LIMIT=4`:
  - After 4 D/DMA grants, the 5th grant is I.
  - `starve_cnt` then returns to 0.
- DMA write `dma_wen=4'b0011`, `dma_addr=0x40`, `dma_store=0xDEADBEEF`, with `dma_ren` also high:
  - `ram_wen=4'b0011`, `ram_ren=0`.
  - `ram_store=0xDEADBEEF`.
- D read granted, then `dren` drops before RAM_DONE:
  - Strobes go low in that cycle and `dwait` stays high.
  - The FSM returns to `ARB_IDLE`, and the next requester is granted after one cycle.
- `rst` asserted in the second cycle of `ARB_ACCESS`:
  - All waits are 1 and all `ram_*` outputs are 0 during reset.
  - After reset, the first request is granted normally with `starve_cnt=0`.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the RAM subsystem: RAM status, arbiter state and owner encodings.
package common_types_pkg;

    typedef enum logic [1:0] {RAM_IDLE, RAM_BUSY, RAM_DONE, RAM_ERR} ram_state_t;

    typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_DMA, OWN_I} arb_owner_t;

    // A data-style requester is active on any byte write enable or a read.
    function automatic logic req_active(input logic [3:0] wen, input logic ren);
        return (|wen) | ren;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection: D > DMA > I, with a starvation override for I.
module ram_arb_pick
    import common_types_pkg::*;
(
    input  logic       d_act,
    input  logic       dma_act,
    input  logic       i_act,
    input  logic       force_i,
    output arb_owner_t pick
);

    always_comb begin
        pick = OWN_NONE;
        if (force_i)      pick = OWN_I;
        else if (d_act)   pick = OWN_D;
        else if (dma_act) pick = OWN_DMA;
        else if (i_act)   pick = OWN_I;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Non-preemptive arbiter for the shared RAM port (CPU data, DMA, instruction fetch).
// The owner is locked until RAM_DONE or until it drops its request.
module ram_arbiter
    import common_types_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [31:0]       iload,
    input  logic              dren,
    input  logic [3:0]        dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dstore,
    output logic              dwait,
    output logic [31:0]       dload,
    input  logic              dma_ren,
    input  logic [3:0]        dma_wen,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_store,
    output logic              dma_wait,
    output logic [31:0]       dma_load,
    output logic              ram_ren,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_store,
    input  logic [31:0]       ram_load,
    input  ram_state_t        ram_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    arb_state_t        state;
    arb_owner_t        owner;
    arb_owner_t        pick;
    logic [SW-1:0]     starve_cnt;

    logic              d_act;
    logic              dma_act;
    logic              force_i;
    logic              owner_act;
    logic [3:0]        sel_wen;
    logic              sel_ren;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_store;

    assign d_act   = req_active(dwen, dren);
    assign dma_act = req_active(dma_wen, dma_ren);
    assign force_i = iren && (starve_cnt == LIMIT);

    ram_arb_pick u_pick (
        .d_act   (d_act),
        .dma_act (dma_act),
        .i_act   (iren),
        .force_i (force_i),
        .pick    (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            if (!iren) starve_cnt <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick != OWN_NONE) begin
                        owner <= pick;
                        state <= ARB_ACCESS;
                        if (iren) begin
                            if (pick == OWN_I)             starve_cnt <= '0;
                            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ARB_ACCESS: begin
                    // Completion or abort both release the port for one idle cycle.
                    if (ram_state == RAM_DONE || !owner_act) begin
                        state <= ARB_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    always_comb begin
        sel_wen   = '0;
        sel_ren   = 1'b0;
        sel_addr  = '0;
        sel_store = '0;
        case (owner)
            OWN_D: begin
                sel_wen   = dwen;
                sel_ren   = dren;
                sel_addr  = daddr;
                sel_store = dstore;
            end
            OWN_DMA: begin
                sel_wen   = dma_wen;
                sel_ren   = dma_ren;
                sel_addr  = dma_addr;
                sel_store = dma_store;
            end
            OWN_I: begin
                sel_ren  = iren;
                sel_addr = iaddr;
            end
            default: ;
        endcase
        owner_act = (|sel_wen) | sel_ren;

        iwait     = 1'b1;
        dwait     = 1'b1;
        dma_wait  = 1'b1;
        ram_ren   = 1'b0;
        ram_wen   = '0;
        ram_addr  = '0;
        ram_store = '0;
        if (!rst && state == ARB_ACCESS) begin
            ram_addr  = sel_addr;
            ram_store = sel_store;
            if (owner_act) begin
                if (|sel_wen) ram_wen = sel_wen;
                else          ram_ren = 1'b1;
            end
            if (ram_state == RAM_DONE) begin
                case (owner)
                    OWN_D:   dwait    = 1'b0;
                    OWN_DMA: dma_wait = 1'b0;
                    OWN_I:   iwait    = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign iload    = ram_load;
    assign dload    = ram_load;
    assign dma_load = ram_load;

endmodule
